// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared widths and channel FSM encoding for the DDR burst arbiter.
package ddr_burst_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_SIZE  = 30;
    localparam int unsigned LEN_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    // Requester index width; a single requester still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_channel_arb.sv
// One arbitrated burst channel: round-robin pick, IDLE/ISSUE/BUSY sequencing,
// strobe routing to the owner and a mux of the owner's data.
module burst_channel_arb
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM    = 2,
    parameter int unsigned W_DATA = DATA_WIDTH,
    parameter int unsigned W_ADDR = ADDR_SIZE,
    parameter int unsigned W_LEN  = LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM-1:0]        req,
    input  logic [NUM*W_ADDR-1:0] addr,
    input  logic [NUM*W_LEN-1:0]  len,
    input  logic [NUM*W_DATA-1:0] data_in,
    output logic [NUM-1:0]        grant,
    output logic                  busy,
    output logic                  burst_req,
    output logic [W_ADDR-1:0]     burst_addr,
    output logic [W_LEN-1:0]      burst_len,
    output logic [W_DATA-1:0]     burst_data,
    input  logic                  burst_valid,
    input  logic                  burst_finish,
    output logic [NUM-1:0]        owner_valid,
    output logic [NUM-1:0]        owner_finish
);

    localparam int unsigned IDX_W = idx_width(NUM);

    arb_state_e        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic              pick_found;

    logic [W_ADDR-1:0] addr_arr [NUM];
    logic [W_LEN-1:0]  len_arr  [NUM];
    logic [W_DATA-1:0] data_arr [NUM];

    for (genvar g = 0; g < NUM; g++) begin : g_unpack
        assign addr_arr[g] = addr[g*W_ADDR +: W_ADDR];
        assign len_arr[g]  = len[g*W_LEN +: W_LEN];
        assign data_arr[g] = data_in[g*W_DATA +: W_DATA];
    end

    // First set request after the last owner, wrapping modulo NUM.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= int'(NUM); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(NUM));
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            ptr        <= IDX_W'(NUM - 1);
            grant      <= '0;
            busy       <= 1'b0;
            burst_req  <= 1'b0;
            burst_addr <= '0;
            burst_len  <= '0;
        end else begin
            grant     <= '0;
            burst_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner      <= pick_idx;
                        burst_addr <= addr_arr[pick_idx];
                        burst_len  <= len_arr[pick_idx];
                        burst_req  <= 1'b1;
                        grant      <= NUM'(1) << pick_idx;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ptr <= owner;
                    // A finish here means a non-compliant downstream; skip BUSY.
                    if (burst_finish) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (burst_finish) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by busy so stray responses in IDLE are dropped.
    assign owner_valid  = (burst_valid  && busy) ? (NUM'(1) << owner) : '0;
    assign owner_finish = (burst_finish && busy) ? (NUM'(1) << owner) : '0;
    assign burst_data   = data_arr[owner];

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Shares one DDR burst port between read and write requesters; the two
// channels are arbitrated independently and may be busy at the same time.
module ddr_burst_arbiter #(
    parameter int unsigned NUM_RD     = 3,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned DATA_WIDTH = ddr_burst_arbiter_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_SIZE  = ddr_burst_arbiter_pkg::ADDR_SIZE,
    parameter int unsigned LEN_WIDTH  = ddr_burst_arbiter_pkg::LEN_WIDTH
) (
    input  logic                         user_clk,
    input  logic                         user_rst_n,

    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_SIZE-1:0]  rd_addr,
    input  logic [NUM_RD*LEN_WIDTH-1:0]  rd_len,
    output logic [NUM_RD-1:0]            rd_grant,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD-1:0]            rd_finish,

    input  logic [NUM_WR-1:0]            wr_req,
    input  logic [NUM_WR*ADDR_SIZE-1:0]  wr_addr,
    input  logic [NUM_WR*LEN_WIDTH-1:0]  wr_len,
    output logic [NUM_WR-1:0]            wr_grant,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]            wr_valid,
    output logic [NUM_WR-1:0]            wr_finish,

    output logic                         burst_read_req,
    output logic [ADDR_SIZE-1:0]         burst_read_addr,
    output logic [LEN_WIDTH-1:0]         burst_read_len,
    input  logic [DATA_WIDTH-1:0]        burst_read_data,
    input  logic                         burst_read_valid,
    input  logic                         burst_read_finish,

    output logic                         burst_write_req,
    output logic [ADDR_SIZE-1:0]         burst_write_addr,
    output logic [LEN_WIDTH-1:0]         burst_write_len,
    output logic [DATA_WIDTH-1:0]        burst_write_data,
    input  logic                         burst_write_valid,
    input  logic                         burst_write_finish,

    output logic                         rd_busy,
    output logic                         wr_busy
);

    // Every read data slot carries the downstream word, so the mux is a broadcast.
    burst_channel_arb #(
        .NUM    (NUM_RD),
        .W_DATA (DATA_WIDTH),
        .W_ADDR (ADDR_SIZE),
        .W_LEN  (LEN_WIDTH)
    ) u_rd_chan (
        .clk          (user_clk),
        .rst_n        (user_rst_n),
        .req          (rd_req),
        .addr         (rd_addr),
        .len          (rd_len),
        .data_in      ({NUM_RD{burst_read_data}}),
        .grant        (rd_grant),
        .busy         (rd_busy),
        .burst_req    (burst_read_req),
        .burst_addr   (burst_read_addr),
        .burst_len    (burst_read_len),
        .burst_data   (rd_data),
        .burst_valid  (burst_read_valid),
        .burst_finish (burst_read_finish),
        .owner_valid  (rd_valid),
        .owner_finish (rd_finish)
    );

    burst_channel_arb #(
        .NUM    (NUM_WR),
        .W_DATA (DATA_WIDTH),
        .W_ADDR (ADDR_SIZE),
        .W_LEN  (LEN_WIDTH)
    ) u_wr_chan (
        .clk          (user_clk),
        .rst_n        (user_rst_n),
        .req          (wr_req),
        .addr         (wr_addr),
        .len          (wr_len),
        .data_in      (wr_data),
        .grant        (wr_grant),
        .busy         (wr_busy),
        .burst_req    (burst_write_req),
        .burst_addr   (burst_write_addr),
        .burst_len    (burst_write_len),
        .burst_data   (burst_write_data),
        .burst_valid  (burst_write_valid),
        .burst_finish (burst_write_finish),
        .owner_valid  (wr_valid),
        .owner_finish (wr_finish)
    );

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter with a small DDR burst model (one WAIT
// cycle after the command, one beat per cycle, then a finish pulse).
module tb_ddr_burst_arbiter;

    localparam int NUM_RD = 3;
    localparam int NUM_WR = 2;
    localparam int DW     = 64;
    localparam int AW     = 30;
    localparam int LW     = 16;
    localparam int MEM_WORDS = 1024;

    logic                   user_clk = 1'b0;
    logic                   user_rst_n;
    logic [NUM_RD-1:0]      rd_req;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*LW-1:0]   rd_len;
    logic [NUM_RD-1:0]      rd_grant;
    logic [DW-1:0]          rd_data;
    logic [NUM_RD-1:0]      rd_valid;
    logic [NUM_RD-1:0]      rd_finish;
    logic [NUM_WR-1:0]      wr_req;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*LW-1:0]   wr_len;
    logic [NUM_WR-1:0]      wr_grant;
    logic [NUM_WR*DW-1:0]   wr_data;
    logic [NUM_WR-1:0]      wr_valid;
    logic [NUM_WR-1:0]      wr_finish;
    logic                   burst_read_req;
    logic [AW-1:0]          burst_read_addr;
    logic [LW-1:0]          burst_read_len;
    logic [DW-1:0]          burst_read_data;
    logic                   burst_read_valid;
    logic                   burst_read_finish;
    logic                   burst_write_req;
    logic [AW-1:0]          burst_write_addr;
    logic [LW-1:0]          burst_write_len;
    logic [DW-1:0]          burst_write_data;
    logic                   burst_write_valid;
    logic                   burst_write_finish;
    logic                   rd_busy;
    logic                   wr_busy;

    logic [63:0] mem [MEM_WORDS];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int wr0_cnt = 0;
    int wr1_cnt = 0;
    int rd_vcnt [NUM_RD];
    int rd_fcnt [NUM_RD];
    int wr_vcnt [NUM_WR];
    int wr_fcnt [NUM_WR];
    int wr_cmd_cnt;
    bit both_busy;
    logic [63:0] rd_beats [$];
    int rd_gnt_q [$];
    int rd_iss_cyc [$];
    int rd_fin_cyc [$];

    ddr_burst_arbiter dut (
        .user_clk           (user_clk),
        .user_rst_n         (user_rst_n),
        .rd_req             (rd_req),
        .rd_addr            (rd_addr),
        .rd_len             (rd_len),
        .rd_grant           (rd_grant),
        .rd_data            (rd_data),
        .rd_valid           (rd_valid),
        .rd_finish          (rd_finish),
        .wr_req             (wr_req),
        .wr_addr            (wr_addr),
        .wr_len             (wr_len),
        .wr_grant           (wr_grant),
        .wr_data            (wr_data),
        .wr_valid           (wr_valid),
        .wr_finish          (wr_finish),
        .burst_read_req     (burst_read_req),
        .burst_read_addr    (burst_read_addr),
        .burst_read_len     (burst_read_len),
        .burst_read_data    (burst_read_data),
        .burst_read_valid   (burst_read_valid),
        .burst_read_finish  (burst_read_finish),
        .burst_write_req    (burst_write_req),
        .burst_write_addr   (burst_write_addr),
        .burst_write_len    (burst_write_len),
        .burst_write_data   (burst_write_data),
        .burst_write_valid  (burst_write_valid),
        .burst_write_finish (burst_write_finish),
        .rd_busy            (rd_busy),
        .wr_busy            (wr_busy)
    );

    always #5 user_clk = ~user_clk;
    always @(posedge user_clk) cyc = cyc + 1;

    // Write requesters advance their data on every consumed beat.
    assign wr_data = {64'hB0 + 64'(wr1_cnt), 64'hA0 + 64'(wr0_cnt)};

    initial begin : wr_src_counter
        forever begin
            @(negedge user_clk);
            if (wr_valid[0]) wr0_cnt = wr0_cnt + 1;
            if (wr_valid[1]) wr1_cnt = wr1_cnt + 1;
        end
    end

    initial begin : rd_model
        int a;
        int n;
        bit abort;
        burst_read_valid  = 1'b0;
        burst_read_finish = 1'b0;
        burst_read_data   = '0;
        forever begin
            @(posedge user_clk); #1;
            if (user_rst_n && burst_read_req) begin
                a = int'(burst_read_addr >> 3);
                n = int'(burst_read_len);
                abort = 1'b0;
                @(posedge user_clk); #1;
                for (int i = 0; i < n && !abort; i++) begin
                    if (!user_rst_n) begin
                        abort = 1'b1;
                    end else begin
                        burst_read_data  = mem[(a + i) % MEM_WORDS];
                        burst_read_valid = 1'b1;
                        @(posedge user_clk); #1;
                    end
                end
                burst_read_valid = 1'b0;
                if (!abort && user_rst_n) begin
                    burst_read_finish = 1'b1;
                    @(posedge user_clk); #1;
                    burst_read_finish = 1'b0;
                end
            end
        end
    end

    initial begin : wr_model
        int a;
        int n;
        bit abort;
        burst_write_valid  = 1'b0;
        burst_write_finish = 1'b0;
        forever begin
            @(posedge user_clk); #1;
            if (user_rst_n && burst_write_req) begin
                a = int'(burst_write_addr >> 3);
                n = int'(burst_write_len);
                abort = 1'b0;
                @(posedge user_clk); #1;
                for (int i = 0; i < n && !abort; i++) begin
                    if (!user_rst_n) begin
                        abort = 1'b1;
                    end else begin
                        burst_write_valid = 1'b1;
                        #1;
                        mem[(a + i) % MEM_WORDS] = burst_write_data;
                        @(posedge user_clk); #1;
                    end
                end
                burst_write_valid = 1'b0;
                if (!abort && user_rst_n) begin
                    burst_write_finish = 1'b1;
                    @(posedge user_clk); #1;
                    burst_write_finish = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge user_clk);
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_valid[2'(i)]) begin
                    rd_vcnt[i] = rd_vcnt[i] + 1;
                    rd_beats.push_back(rd_data);
                end
                if (rd_finish[2'(i)]) begin
                    rd_fcnt[i] = rd_fcnt[i] + 1;
                    rd_fin_cyc.push_back(cyc);
                end
                if (burst_read_req && rd_grant[2'(i)]) rd_gnt_q.push_back(i);
            end
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_valid[1'(i)])  wr_vcnt[i] = wr_vcnt[i] + 1;
                if (wr_finish[1'(i)]) wr_fcnt[i] = wr_fcnt[i] + 1;
            end
            if (burst_read_req)  rd_iss_cyc.push_back(cyc);
            if (burst_write_req) wr_cmd_cnt = wr_cmd_cnt + 1;
            if (rd_busy && wr_busy) both_busy = 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        for (int i = 0; i < NUM_RD; i++) begin rd_vcnt[i] = 0; rd_fcnt[i] = 0; end
        for (int i = 0; i < NUM_WR; i++) begin wr_vcnt[i] = 0; wr_fcnt[i] = 0; end
        wr_cmd_cnt = 0;
        both_busy  = 1'b0;
        rd_beats.delete();
        rd_gnt_q.delete();
        rd_iss_cyc.delete();
        rd_fin_cyc.delete();
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge user_clk);
            if (!rd_busy && !wr_busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_rd_grant(input int max_cyc, output logic [NUM_RD-1:0] g);
        g = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge user_clk);
            if (rd_grant != '0) begin
                g = rd_grant;
                return;
            end
        end
    endtask

    task automatic test_reset();
        user_rst_n = 1'b1;
        #2 user_rst_n = 1'b0;
        #1;
        checks++; if (burst_read_req !== 1'b0) $display("FAIL rst_rd_req got=%b want=0", burst_read_req); else passes++;
        checks++; if (burst_write_req !== 1'b0) $display("FAIL rst_wr_req got=%b want=0", burst_write_req); else passes++;
        repeat (3) @(negedge user_clk);
        checks++; if (burst_read_addr !== '0 || burst_read_len !== '0) $display("FAIL rst_rd_cmd got=%h/%h want=0/0", burst_read_addr, burst_read_len); else passes++;
        checks++; if (burst_write_addr !== '0 || burst_write_len !== '0) $display("FAIL rst_wr_cmd got=%h/%h want=0/0", burst_write_addr, burst_write_len); else passes++;
        checks++; if (rd_grant !== 3'b000 || wr_grant !== 2'b00) $display("FAIL rst_grant got=%b/%b want=000/00", rd_grant, wr_grant); else passes++;
        checks++; if (rd_busy !== 1'b0 || wr_busy !== 1'b0) $display("FAIL rst_busy got=%b/%b want=0/0", rd_busy, wr_busy); else passes++;
        user_rst_n = 1'b1;
        repeat (2) @(negedge user_clk);
        checks++; if (rd_busy !== 1'b0 || burst_read_req !== 1'b0) $display("FAIL idle_no_req got=%b/%b want=0/0", rd_busy, burst_read_req); else passes++;
    endtask

    task automatic test_rr_rotation();
        bit ok;
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
        clear_stats();
        rd_addr[0*AW +: AW] = 30'h000;
        rd_addr[1*AW +: AW] = 30'h040;
        rd_addr[2*AW +: AW] = 30'h080;
        rd_len = {16'd2, 16'd2, 16'd2};
        rd_req = 3'b111;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge user_clk);
            if (rd_gnt_q.size() >= 6) begin ok = 1'b1; break; end
        end
        rd_req = 3'b000;
        checks++; if (!ok) $display("FAIL rr_six_grants got=%0d want=6", rd_gnt_q.size()); else passes++;
        wait_idle(50, ok);
        checks++; if (!ok) $display("FAIL rr_idle got=busy want=idle"); else passes++;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rd_gnt_q.size() <= k || rd_gnt_q[k] !== exp_order[k])
                $display("FAIL rr_order[%0d] got=%0d want=%0d", k, (rd_gnt_q.size() > k) ? rd_gnt_q[k] : -1, exp_order[k]);
            else passes++;
        end
        for (int k = 1; k < 6; k++) begin
            checks++;
            if (rd_iss_cyc.size() <= k || rd_fin_cyc.size() < k || rd_iss_cyc[k] - rd_fin_cyc[k-1] != 2)
                $display("FAIL rr_spacing[%0d] got=%0d want=2", k,
                         (rd_iss_cyc.size() > k && rd_fin_cyc.size() >= k) ? rd_iss_cyc[k] - rd_fin_cyc[k-1] : -1);
            else passes++;
        end
        checks++; if (rd_vcnt[0] != 4 || rd_vcnt[1] != 4 || rd_vcnt[2] != 4)
            $display("FAIL rr_beats got=%0d/%0d/%0d want=4/4/4", rd_vcnt[0], rd_vcnt[1], rd_vcnt[2]); else passes++;
    endtask

    task automatic test_single_read();
        bit ok;
        logic [63:0] exp;
        clear_stats();
        rd_addr[1*AW +: AW] = 30'h100;
        rd_len[1*LW +: LW]  = 16'd4;
        rd_req = 3'b010;
        @(negedge user_clk);
        checks++; if (burst_read_req !== 1'b1) $display("FAIL single_req got=%b want=1", burst_read_req); else passes++;
        checks++; if (burst_read_addr !== 30'h100 || burst_read_len !== 16'd4) $display("FAIL single_cmd got=%h/%0d want=100/4", burst_read_addr, burst_read_len); else passes++;
        checks++; if (rd_grant !== 3'b010) $display("FAIL single_grant got=%b want=010", rd_grant); else passes++;
        rd_req = 3'b000;
        @(negedge user_clk);
        checks++; if (burst_read_req !== 1'b0 || rd_grant !== 3'b000) $display("FAIL single_pulse got=%b/%b want=0/000", burst_read_req, rd_grant); else passes++;
        wait_idle(40, ok);
        checks++; if (!ok) $display("FAIL single_idle got=busy want=idle"); else passes++;
        checks++; if (rd_vcnt[1] != 4) $display("FAIL single_beats got=%0d want=4", rd_vcnt[1]); else passes++;
        for (int j = 0; j < 4; j++) begin
            exp = 64'hCAFE_0000_0000_0020 + 64'(j);
            checks++;
            if (rd_beats.size() <= j || rd_beats[j] !== exp)
                $display("FAIL single_data[%0d] got=%h want=%h", j, (rd_beats.size() > j) ? rd_beats[j] : 64'hx, exp);
            else passes++;
        end
        checks++; if (rd_fcnt[1] != 1) $display("FAIL single_finish got=%0d want=1", rd_fcnt[1]); else passes++;
        checks++; if (rd_vcnt[0] != 0 || rd_vcnt[2] != 0) $display("FAIL single_others got=%0d/%0d want=0/0", rd_vcnt[0], rd_vcnt[2]); else passes++;
    endtask

    task automatic test_concurrent();
        bit ok;
        logic [NUM_RD-1:0] g;
        clear_stats();
        wr0_cnt = 0;
        wr_addr[0*AW +: AW] = 30'h200;
        wr_len[0*LW +: LW]  = 16'd3;
        rd_addr[2*AW +: AW] = 30'h200;
        rd_len[2*LW +: LW]  = 16'd3;
        wr_req = 2'b01;
        rd_req = 3'b100;
        @(negedge user_clk);
        checks++; if (wr_grant !== 2'b01 || rd_grant !== 3'b100) $display("FAIL conc_grants got=%b/%b want=01/100", wr_grant, rd_grant); else passes++;
        wr_req = 2'b00;
        rd_req = 3'b000;
        wait_idle(40, ok);
        checks++; if (!ok) $display("FAIL conc_idle got=busy want=idle"); else passes++;
        checks++; if (!both_busy) $display("FAIL conc_both_busy got=0 want=1"); else passes++;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (mem[16'h40 + j] !== 64'hA0 + 64'(j)) $display("FAIL conc_mem[%0d] got=%h want=%h", j, mem[16'h40 + j], 64'hA0 + 64'(j)); else passes++;
        end
        checks++; if (wr_vcnt[0] != 3 || wr_fcnt[0] != 1) $display("FAIL conc_wr_strobes got=%0d/%0d want=3/1", wr_vcnt[0], wr_fcnt[0]); else passes++;
        clear_stats();
        rd_addr[0*AW +: AW] = 30'h200;
        rd_len[0*LW +: LW]  = 16'd3;
        rd_req = 3'b001;
        wait_rd_grant(10, g);
        rd_req = 3'b000;
        checks++; if (g !== 3'b001) $display("FAIL readback_grant got=%b want=001", g); else passes++;
        wait_idle(40, ok);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (rd_beats.size() <= j || rd_beats[j] !== 64'hA0 + 64'(j))
                $display("FAIL readback_data[%0d] got=%h want=%h", j, (rd_beats.size() > j) ? rd_beats[j] : 64'hx, 64'hA0 + 64'(j));
            else passes++;
        end
    endtask

    task automatic test_zero_write();
        bit ok;
        clear_stats();
        wr_addr[1*AW +: AW] = 30'h300;
        wr_len[1*LW +: LW]  = 16'd0;
        wr_req = 2'b10;
        @(negedge user_clk);
        checks++; if (wr_grant !== 2'b10 || burst_write_req !== 1'b1 || burst_write_len !== 16'd0)
            $display("FAIL zero_issue got=%b/%b/%0d want=10/1/0", wr_grant, burst_write_req, burst_write_len); else passes++;
        wr_req = 2'b00;
        wait_idle(20, ok);
        checks++; if (!ok) $display("FAIL zero_idle got=busy want=idle"); else passes++;
        checks++; if (wr_cmd_cnt != 1) $display("FAIL zero_cmds got=%0d want=1", wr_cmd_cnt); else passes++;
        checks++; if (wr_vcnt[1] != 0 || wr_fcnt[1] != 1) $display("FAIL zero_strobes got=%0d/%0d want=0/1", wr_vcnt[1], wr_fcnt[1]); else passes++;
        checks++; if (mem[16'h60] !== 64'hCAFE_0000_0000_0060) $display("FAIL zero_mem got=%h want=cafe000000000060", mem[16'h60]); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [NUM_RD-1:0] g;
        clear_stats();
        rd_addr[0*AW +: AW] = 30'h080;
        rd_len[0*LW +: LW]  = 16'd8;
        rd_req = 3'b001;
        wait_rd_grant(10, g);
        rd_req = 3'b000;
        checks++; if (g !== 3'b001) $display("FAIL mid_grant got=%b want=001", g); else passes++;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge user_clk);
            if (rd_vcnt[0] == 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) $display("FAIL mid_beat2 got=%0d want=2", rd_vcnt[0]); else passes++;
        #1 user_rst_n = 1'b0;
        #1;
        checks++; if (burst_read_addr !== '0 || burst_read_len !== '0) $display("FAIL mid_async_cmd got=%h/%0d want=0/0", burst_read_addr, burst_read_len); else passes++;
        checks++; if (rd_busy !== 1'b0 || rd_valid !== 3'b000) $display("FAIL mid_async_busy got=%b/%b want=0/000", rd_busy, rd_valid); else passes++;
        rd_addr[2*AW +: AW] = 30'h100;
        rd_len[0*LW +: LW]  = 16'd1;
        rd_len[2*LW +: LW]  = 16'd1;
        rd_req = 3'b101;
        repeat (3) @(negedge user_clk);
        checks++; if (rd_fcnt[0] != 0 || rd_grant !== 3'b000) $display("FAIL mid_no_finish got=%0d/%b want=0/000", rd_fcnt[0], rd_grant); else passes++;
        user_rst_n = 1'b1;
        wait_rd_grant(10, g);
        rd_req = 3'b100;
        checks++; if (g !== 3'b001) $display("FAIL post_rst_first got=%b want=001", g); else passes++;
        checks++; if (rd_fcnt[0] != 0) $display("FAIL post_rst_finish got=%0d want=0", rd_fcnt[0]); else passes++;
        wait_rd_grant(20, g);
        rd_req = 3'b000;
        checks++; if (g !== 3'b100) $display("FAIL post_rst_second got=%b want=100", g); else passes++;
        wait_idle(20, ok);
        checks++; if (!ok || rd_fcnt[0] != 1 || rd_fcnt[2] != 1) $display("FAIL post_rst_done got=%0d/%0d want=1/1", rd_fcnt[0], rd_fcnt[2]); else passes++;
    endtask

    initial begin : main
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = {32'hCAFE_0000, 32'(i)};
        rd_req  = '0;
        rd_addr = '0;
        rd_len  = '0;
        wr_req  = '0;
        wr_addr = '0;
        wr_len  = '0;
        clear_stats();
        test_reset();
        test_rr_rotation();
        test_single_read();
        test_concurrent();
        test_zero_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
